req_capture_encoder8: RTL and testbench

//   Sequential front end for the 8-to-3 encoder path. Captures request pulses
//   on 8 one-hot/multi-hot lines into a pending register.

---
 rtl/req_capture_encoder8.sv | 144 ++++++++++++++
 tb/tb_req_capture_encoder8.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_capture_encoder8.sv
// ---------------------------------------------------------------------------
// req_capture_encoder8
//   Sequential front end for the 8-to-3 encoder path. Request pulses are
//   captured into a pending register and served one at a time as a 3-bit
//   index over a valid/ready handshake.
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     req_i[7:0]  request lines (bit k high = request k this cycle)
//     clr_i       synchronous clear of pending and overflow
//     out_valid   out_idx holds a served request
//     out_ready   consumer accepts out_idx when out_valid && out_ready
//     out_idx[2:0] index of served request
//     pending_o   registered pending vector
//     overflow_o  sticky: a request hit an already-pending, unserved bit
//
//   Configuration macro: REQ_ENC_ROUND_ROBIN_EN
//     defined   -> rotating priority starting below the last served index
//     undefined -> fixed priority, highest index wins
// ---------------------------------------------------------------------------
module req_capture_encoder8 #(
    localparam int unsigned N_REQ = 8,
    localparam int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             clr_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pending_o,
    output logic             overflow_o
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic [IDX_W-1:0] sel_idx;
    logic [N_REQ-1:0] served_mask;
    logic             load;

`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] cand;

    // Rotating search last-1, last-2, ... last-8 (== last); the nearest wins,
    // so iterate from farthest to nearest and let later hits overwrite.
    always_comb begin
        sel_idx = '0;
        cand    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = last_q - IDX_W'(i);
            if (pending_q[cand]) sel_idx = cand;
        end
    end
`else
    // Fixed priority: ascending scan, highest set bit is the last overwrite.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pending_q[i]) sel_idx = IDX_W'(i);
        end
    end
`endif

    // Next-state, load decision and pending/overflow update.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        served_mask = '0;
        load        = 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
        last_d      = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (!clr_i && (pending_q != '0)) load = 1'b1;
            end
            HOLD: begin
                if (out_ready) begin
                    if (!clr_i && (pending_q != '0)) load = 1'b1;
                    else                             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d     = HOLD;
            idx_d       = sel_idx;
            served_mask = N_REQ'(1) << sel_idx;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            last_d      = sel_idx;
`endif
        end

        // Clear dominates; otherwise a new request wins over the serve-clear.
        if (clr_i) begin
            pending_d  = '0;
            overflow_d = 1'b0;
        end else begin
            pending_d  = (pending_q & ~served_mask) | req_i;
            overflow_d = overflow_q | (|(req_i & pending_q & ~served_mask));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef REQ_ENC_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= '0;
        else        last_q <= last_d;
    end
`endif

    assign out_valid  = (state_q == HOLD);
    assign out_idx    = idx_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_req_capture_encoder8.sv
module tb_req_capture_encoder8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_i;
    logic       clr_i;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] pending_o;
    logic       overflow_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_idx;
    logic       m_ovf;
    logic [2:0] m_last;

    req_capture_encoder8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .clr_i      (clr_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] pick(input logic [7:0] p);
`ifdef REQ_ENC_ROUND_ROBIN_EN
        for (int d = 1; d <= 8; d++) begin
            int k;
            k = (int'(m_last) + 8 - d) % 8;
            if (p[k]) return 3'(k);
        end
`else
        for (int k = 7; k >= 0; k--) begin
            if (p[k]) return 3'(k);
        end
`endif
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_idx   = 3'd0;
        m_ovf   = 1'b0;
        m_last  = 3'd0;
    endtask

    // One rising edge of the spec's behaviour, using the inputs currently driven.
    task automatic model_edge();
        logic       hs, ld;
        logic [7:0] served;
        logic [2:0] k;
        hs     = m_valid && out_ready;
        ld     = !clr_i && (m_pend != 0) && (!m_valid || hs);
        served = 8'h00;
        k      = pick(m_pend);
        if (ld) served = 8'h01 << k;
        if (clr_i) begin
            m_ovf  = 1'b0;
            m_pend = 8'h00;
        end else begin
            m_ovf  = m_ovf | ((req_i & m_pend & ~served) != 0);
            m_pend = (m_pend & ~served) | req_i;
        end
        if (ld) begin
            m_valid = 1'b1;
            m_idx   = k;
            m_last  = k;
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},   8'(out_valid),  8'(m_valid));
        chk({tag, ".idx"},     8'(out_idx),    8'(m_idx));
        chk({tag, ".pending"}, pending_o,      m_pend);
        chk({tag, ".ovf"},     8'(overflow_o), 8'(m_ovf));
    endtask

    // Called at a falling edge: drive, clock once, check at the next falling edge.
    task automatic step(input string tag, input logic [7:0] r, input logic c, input logic rdy);
        req_i     = r;
        clr_i     = c;
        out_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_i     = 8'h00;
        clr_i     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_model("reset");
    endtask

    initial begin
        rst_n     = 1'b0;
        req_i     = 8'h00;
        clr_i     = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Test 1: asynchronous reset mid-HOLD with idx 5
        do_reset();
        step("t1a", 8'h20, 1'b0, 1'b0);
        step("t1b", 8'h20, 1'b0, 1'b0);
        chk("t1.idx_before", 8'(out_idx), 8'd5);
        chk("t1.ovf_before", 8'(overflow_o), 8'd0);
        step("t1c", 8'h20, 1'b0, 1'b0);
        chk("t1.ovf_set", 8'(overflow_o), 8'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1.rst_valid", 8'(out_valid), 8'd0);
        chk("t1.rst_idx",   8'(out_idx),   8'd0);
        chk("t1.rst_pend",  pending_o,     8'h00);
        chk("t1.rst_ovf",   8'(overflow_o), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 2: single request, latency and drain
        do_reset();
        step("t2a", 8'h10, 1'b0, 1'b1);
        chk("t2.no_valid_yet", 8'(out_valid), 8'd0);
        step("t2b", 8'h00, 1'b0, 1'b1);
        chk("t2.valid", 8'(out_valid), 8'd1);
        chk("t2.idx4",  8'(out_idx),   8'd4);
        step("t2c", 8'h00, 1'b0, 1'b1);
        chk("t2.drop", 8'(out_valid), 8'd0);
        chk("t2.pend0", pending_o, 8'h00);

        // Test 3: two requests served back to back
        do_reset();
        step("t3a", 8'h81, 1'b0, 1'b1);
        step("t3b", 8'h00, 1'b0, 1'b1);
        chk("t3.idx7", 8'(out_idx), 8'd7);
        step("t3c", 8'h00, 1'b0, 1'b1);
        chk("t3.idx0", 8'(out_idx), 8'd0);
        chk("t3.valid", 8'(out_valid), 8'd1);
        step("t3d", 8'h00, 1'b0, 1'b1);
        chk("t3.drop", 8'(out_valid), 8'd0);

        // Test 4: stalled consumer, repeat requests and overflow
        do_reset();
        step("t4a", 8'h04, 1'b0, 1'b0);
        step("t4b", 8'h00, 1'b0, 1'b0);
        step("t4c", 8'h04, 1'b0, 1'b0);
        chk("t4.pend04", pending_o, 8'h04);
        chk("t4.ovf0",   8'(overflow_o), 8'd0);
        step("t4d", 8'h00, 1'b0, 1'b0);
        step("t4e", 8'h04, 1'b0, 1'b0);
        chk("t4.ovf1",  8'(overflow_o), 8'd1);
        chk("t4.idx2",  8'(out_idx), 8'd2);
        chk("t4.valid", 8'(out_valid), 8'd1);

        // Test 5: clear while holding does not retract out_valid
        do_reset();
        step("t5a", 8'h0F, 1'b0, 1'b0);
        step("t5b", 8'h08, 1'b0, 1'b0);
        chk("t5.pend0F", pending_o, 8'h0F);
        chk("t5.idx3",   8'(out_idx), 8'd3);
        step("t5c", 8'h00, 1'b1, 1'b0);
        chk("t5.clr_pend",  pending_o, 8'h00);
        chk("t5.clr_valid", 8'(out_valid), 8'd1);
        chk("t5.clr_idx",   8'(out_idx), 8'd3);
        step("t5d", 8'h00, 1'b0, 1'b1);
        chk("t5.drop", 8'(out_valid), 8'd0);

        // Test 6: request held, consumer always ready
        do_reset();
        step("t6a", 8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step("t6", 8'h81, 1'b0, 1'b1);
`ifdef REQ_ENC_ROUND_ROBIN_EN
            chk("t6.idx_rr", 8'(out_idx), (i % 2 == 0) ? 8'd7 : 8'd0);
`else
            chk("t6.idx_fix", 8'(out_idx), 8'd7);
`endif
            chk("t6.ovf", 8'(overflow_o), 8'd1);
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            logic       c, rdy;
            r   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            c   = ($urandom_range(0, 29) == 0);
            rdy = (i >= 300) ? 1'b1 : ($urandom_range(0, 2) != 0);
            step("rand", r, c, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
